// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU fetch port, host (UART loader) port,
// lock handshake and the single-port memory port.
//   slave  : arbiter view (requests in, grants/read data/memory controls out)
//   master : requester/memory view (the opposite directions)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [31:0]       h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [31:0]       h_rdata;
  logic              h_lock;
  logic              h_locked;
  logic              cpu_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr, h_req, h_we, h_addr, h_wdata, h_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, h_gnt, h_rvalid, h_rdata,
           h_locked, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, h_req, h_we, h_addr, h_wdata, h_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, h_gnt, h_rvalid, h_rdata,
           h_locked, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 32-bit memory between the CPU fetch
// port and a host loader port. Grants are combinational; read data returns
// one cycle after the grant. Round-robin on contention; the host can take
// exclusive ownership (lock) which stalls the CPU.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - mem_arbiter_if.slave: fetch port (f_*), host port (h_*),
//           lock (h_lock/h_locked/cpu_stall), memory port (mem_*)
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HELD} lock_state_t;

  lock_state_t state, state_nxt;

  logic        last_host;   // 1: host won the most recent grant
  logic        f_pend;      // fetch read data due this cycle
  logic        f_mis;       // pending fetch was misaligned
  logic        h_pend;      // host read data due this cycle
  logic [31:0] f_hold;
  logic [31:0] h_hold;
  logic        f_gnt_c;
  logic        h_gnt_c;
  logic        f_aligned;
  logic [31:0] f_rdata_c;
  logic [31:0] h_rdata_c;

  // Upper fetch address bits fold away: the address wraps modulo memory size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.f_addr[31:ADDR_W+2];

  assign f_aligned = (bus.f_addr[1:0] == 2'b00);

  // Lock FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Grants and next state
  always_comb begin
    f_gnt_c   = 1'b0;
    h_gnt_c   = 1'b0;
    state_nxt = state;
    if (reset) begin
      if (state == RUN) begin
        if (bus.f_req && bus.h_req) begin
          f_gnt_c = last_host;
          h_gnt_c = !last_host;
        end else begin
          f_gnt_c = bus.f_req;
          h_gnt_c = bus.h_req;
        end
      end else begin
        h_gnt_c = bus.h_req;
      end
    end
    case (state)
      RUN:   if (bus.h_lock) state_nxt = DRAIN;
      // Fetches are never granted while draining, so the only in-flight
      // read is the one returning during DRAIN itself.
      DRAIN: if (!bus.h_lock)  state_nxt = RUN;
             else if (!f_gnt_c) state_nxt = HELD;
      HELD:  if (!bus.h_lock) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Memory port and handshake outputs
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (f_gnt_c) begin
      bus.mem_en   = f_aligned;
      bus.mem_addr = bus.f_addr[ADDR_W+1:2];
    end else if (h_gnt_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.h_we;
      bus.mem_addr  = bus.h_addr;
      bus.mem_wdata = bus.h_wdata;
    end
  end

  always_comb begin
    f_rdata_c = f_hold;
    h_rdata_c = h_hold;
    if (f_pend) f_rdata_c = f_mis ? NOP_WORD : bus.mem_rdata;
    if (h_pend) h_rdata_c = bus.mem_rdata;
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.h_gnt     = h_gnt_c;
  assign bus.f_rvalid  = f_pend;
  assign bus.f_err     = f_pend & f_mis;
  assign bus.f_rdata   = f_rdata_c;
  assign bus.h_rvalid  = h_pend;
  assign bus.h_rdata   = h_rdata_c;
  assign bus.cpu_stall = (state != RUN);
  assign bus.h_locked  = (state == HELD);

  // Response pipeline, round-robin pointer and read-data hold registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_host <= 1'b1;
      f_pend    <= 1'b0;
      f_mis     <= 1'b0;
      h_pend    <= 1'b0;
      f_hold    <= '0;
      h_hold    <= '0;
    end else begin
      f_pend <= f_gnt_c;
      f_mis  <= f_gnt_c & !f_aligned;
      h_pend <= h_gnt_c & !bus.h_we;
      if (f_gnt_c)      last_host <= 1'b0;
      else if (h_gnt_c) last_host <= 1'b1;
      if (f_pend) f_hold <= f_rdata_c;
      if (h_pend) h_hold <= h_rdata_c;
    end
  end

endmodule
